// File: rtl/colormap_to_gray_if.sv
// Pixel stream handshake between the colormap_to_gray core and its neighbours.
interface colormap_to_gray_if;
  logic [7:0] r_in, g_in, b_in;
  logic [1:0] mode_sel;
  logic       data_valid;
  logic       in_ready;
  logic [7:0] gray_out;
  logic       miss_out;
  logic       data_out_valid;
  logic       out_ready;

  modport slave (
    input  r_in, g_in, b_in, mode_sel, data_valid, out_ready,
    output in_ready, gray_out, miss_out, data_out_valid
  );
  modport master (
    output r_in, g_in, b_in, mode_sel, data_valid, out_ready,
    input  in_ready, gray_out, miss_out, data_out_valid
  );
endinterface

// File: rtl/colormap_to_gray.sv
// RGB -> gray converter: luminance, inverse jet, green channel or max, 2-stage pipe.
// Define C2G_ROUND_EN to round the luminance path to nearest instead of truncating.
module colormap_to_gray #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  colormap_to_gray_if.slave px,
  input  logic             miss_clr,
  output logic [CNT_W-1:0] miss_cnt
);
`ifdef C2G_ROUND_EN
  localparam logic [15:0] RND = 16'd128;
`else
  localparam logic [15:0] RND = 16'd0;
`endif

  typedef struct packed {
    logic [7:0]  r, g, b;
    logic [1:0]  mode;
    logic [15:0] pr, pg, pb;
    logic [3:0]  hit;   // jet rule matches, bit 0 = highest priority
  } s1_t;

  s1_t        s1, s1_d;
  logic [1:0] vld_pipe;  // [0] stage 1, [1] output stage
  logic       adv, accept;
  logic [15:0] sum;
  logic [7:0]  luma, jet, vmax, gray_d;
  logic        miss_d;

  assign adv       = !vld_pipe[1] || px.out_ready;
  assign accept    = px.data_valid && adv;
  assign px.in_ready       = adv;
  assign px.data_out_valid = vld_pipe[1];

  // Stage 1 inputs: products and rule flags computed from the live pixel
  always_comb begin
    s1_d.r    = px.r_in;
    s1_d.g    = px.g_in;
    s1_d.b    = px.b_in;
    s1_d.mode = px.mode_sel;
    s1_d.pr   = 16'(px.r_in) * 16'd77;
    s1_d.pg   = 16'(px.g_in) * 16'd150;
    s1_d.pb   = 16'(px.b_in) * 16'd29;
    s1_d.hit[0] = (px.r_in == 8'd0) && (px.b_in == 8'd255) && (px.g_in != 8'd255);
    s1_d.hit[1] = (px.r_in == 8'd0) && (px.g_in == 8'd0);
    s1_d.hit[2] = (px.g_in == 8'd255) && (px.r_in != 8'd255);
    s1_d.hit[3] = (px.r_in == 8'd255) && (px.b_in == 8'd0);
  end

  // Stage 2 select
  always_comb begin
    sum  = s1.pr + s1.pg + s1.pb + RND;
    luma = sum[15:8];
    vmax = (s1.r > s1.g) ? s1.r : s1.g;
    if (s1.b > vmax) vmax = s1.b;
    jet = luma;
    if      (s1.hit[0]) jet = 8'd64  + {2'b00, s1.g[7:2]};
    else if (s1.hit[1]) jet = {2'b00, s1.b[7:2]};
    else if (s1.hit[2]) jet = 8'd128 + {2'b00, s1.r[7:2]};
    else if (s1.hit[3]) jet = 8'd192 + {2'b00, ~s1.g[7:2]};
    gray_d = luma;
    miss_d = 1'b0;
    case (s1.mode)
      2'b00: gray_d = luma;
      2'b01: begin
        gray_d = jet;
        miss_d = ~|s1.hit;
      end
      2'b10: gray_d = s1.g;
      2'b11: gray_d = vmax;
      default: gray_d = luma;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe    <= '0;
      s1          <= '0;
      px.gray_out <= '0;
      px.miss_out <= 1'b0;
    end else if (adv) begin
      vld_pipe <= {vld_pipe[0], accept};
      if (accept) s1 <= s1_d;
      if (vld_pipe[0]) begin
        px.gray_out <= gray_d;
        px.miss_out <= miss_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      miss_cnt <= '0;
    else if (miss_clr)
      miss_cnt <= '0;
    else if (px.data_out_valid && px.out_ready && px.miss_out && !(&miss_cnt))
      miss_cnt <= miss_cnt + 1'b1;
  end
endmodule

// File: tb/tb_colormap_to_gray.sv
// Directed bench for colormap_to_gray: vector table plus stall/reset/counter sequences.
module tb_colormap_to_gray;
  localparam int CNT_W = 2;
`ifdef C2G_ROUND_EN
  localparam int LUMA_RED = 77;
`else
  localparam int LUMA_RED = 76;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic miss_clr = 1'b0;
  logic [CNT_W-1:0] miss_cnt;
  int checks = 0;
  int errors = 0;

  colormap_to_gray_if bus ();
  colormap_to_gray #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .px(bus), .miss_clr(miss_clr), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] r, g, b;
    logic [1:0] m;
    int         gray;
    logic       miss;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] r, g, b, input logic [1:0] m, input logic v);
    bus.r_in = r; bus.g_in = g; bus.b_in = b; bus.mode_sel = m; bus.data_valid = v;
  endtask

  // Single pixel, no stall; returns with the result on the output register.
  task automatic send_one(input logic [7:0] r, g, b, input logic [1:0] m);
    drive(r, g, b, m, 1'b1);
    step();
    bus.data_valid = 1'b0;
    step();
  endtask

  function automatic logic [23:0] jet_enc(input int i);
    logic [7:0] k4;
    k4 = 8'((i % 64) * 4);
    case (i / 64)
      0: return {8'd0, 8'd0, k4};
      1: return {8'd0, k4, 8'd255};
      2: return {k4, 8'd255, 8'd255 - k4};
      default: return {8'd255, 8'd255 - k4, 8'd0};
    endcase
  endfunction

  vec_t tbl[14];
  logic [23:0] px;
  int got[$];
  int held;
  int sent;

  initial begin
    tbl[0]  = '{8'd255, 8'd0,   8'd0,   2'b00, LUMA_RED, 1'b0};
    tbl[1]  = '{8'd255, 8'd255, 8'd255, 2'b00, 255, 1'b0};
    tbl[2]  = '{8'd10,  8'd20,  8'd30,  2'b00, 18,  1'b0};
    tbl[3]  = '{8'd12,  8'd200, 8'd45,  2'b10, 200, 1'b0};
    tbl[4]  = '{8'd12,  8'd200, 8'd45,  2'b11, 200, 1'b0};
    tbl[5]  = '{8'd250, 8'd3,   8'd7,   2'b11, 250, 1'b0};
    tbl[6]  = '{8'd7,   8'd3,   8'd250, 2'b11, 250, 1'b0};
    tbl[7]  = '{8'd1,   8'd2,   8'd3,   2'b10, 2,   1'b0};
    tbl[8]  = '{8'd0,   8'd0,   8'd255, 2'b01, 64,  1'b0};
    tbl[9]  = '{8'd0,   8'd255, 8'd255, 2'b01, 128, 1'b0};
    tbl[10] = '{8'd252, 8'd255, 8'd3,   2'b01, 191, 1'b0};
    tbl[11] = '{8'd255, 8'd3,   8'd0,   2'b01, 255, 1'b0};
    tbl[12] = '{8'd0,   8'd255, 8'd0,   2'b01, 128, 1'b0};
    tbl[13] = '{8'd255, 8'd0,   8'd0,   2'b01, 255, 1'b0};

    drive(8'd0, 8'd0, 8'd0, 2'b00, 1'b0);
    bus.out_ready = 1'b1;
    #12;
    chk("reset gray_out", int'(bus.gray_out), 0);
    chk("reset miss_out", int'(bus.miss_out), 0);
    chk("reset valid", int'(bus.data_out_valid), 0);
    chk("reset miss_cnt", int'(miss_cnt), 0);
    chk("reset in_ready", int'(bus.in_ready), 1);
    rst_n = 1'b1;
    step();

    foreach (tbl[i]) begin
      send_one(tbl[i].r, tbl[i].g, tbl[i].b, tbl[i].m);
      chk($sformatf("vec%0d valid", i), int'(bus.data_out_valid), 1);
      chk($sformatf("vec%0d gray", i), int'(bus.gray_out), tbl[i].gray);
      chk($sformatf("vec%0d miss", i), int'(bus.miss_out), int'(tbl[i].miss));
    end
    step();

    // Luminance back-to-back
    drive(8'd255, 8'd0, 8'd0, 2'b00, 1'b1);
    step();
    drive(8'd255, 8'd255, 8'd255, 2'b00, 1'b1);
    step();
    bus.data_valid = 1'b0;
    chk("b2b first valid", int'(bus.data_out_valid), 1);
    chk("b2b first gray", int'(bus.gray_out), LUMA_RED);
    step();
    chk("b2b second valid", int'(bus.data_out_valid), 1);
    chk("b2b second gray", int'(bus.gray_out), 255);
    step();

    // Full jet sweep streamed one pixel per clock
    for (int i = 0; i < 257; i++) begin
      if (i < 256) begin
        px = jet_enc(i);
        drive(px[23:16], px[15:8], px[7:0], 2'b01, 1'b1);
      end else bus.data_valid = 1'b0;
      step();
      if (i >= 1) begin
        chk($sformatf("jet%0d valid", i - 1), int'(bus.data_out_valid), 1);
        chk($sformatf("jet%0d gray", i - 1), int'(bus.gray_out), i - 1);
        chk($sformatf("jet%0d miss", i - 1), int'(bus.miss_out), 0);
      end
    end
    step();
    chk("miss_cnt after clean runs", int'(miss_cnt), 0);

    // Backpressure: 5 pixels, out_ready low for 3 cycles
    sent = 0;
    held = 0;
    for (int cyc = 0; cyc < 15; cyc++) begin
      bus.out_ready = !(cyc >= 3 && cyc <= 5);
      if (sent < 5) drive(8'd1, 8'(10 * (sent + 1)), 8'd2, 2'b10, 1'b1);
      else bus.data_valid = 1'b0;
      #1;
      if (cyc == 3) held = int'(bus.gray_out);
      if (cyc >= 3 && cyc <= 5) begin
        chk("stall in_ready", int'(bus.in_ready), 0);
        chk("stall valid held", int'(bus.data_out_valid), 1);
        chk("stall gray held", int'(bus.gray_out), held);
      end
      if (bus.data_valid && bus.in_ready) sent++;
      if (bus.data_out_valid && bus.out_ready) got.push_back(int'(bus.gray_out));
      step();
    end
    bus.out_ready = 1'b1;
    chk("bp count", got.size(), 5);
    for (int k = 0; k < 5; k++)
      chk($sformatf("bp order%0d", k), (k < got.size()) ? got[k] : -1, 10 * (k + 1));

    // Reset mid-stream
    drive(8'd5, 8'd77, 8'd5, 2'b10, 1'b1);
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("midrst gray", int'(bus.gray_out), 0);
    chk("midrst valid", int'(bus.data_out_valid), 0);
    chk("midrst miss", int'(bus.miss_out), 0);
    chk("midrst in_ready", int'(bus.in_ready), 1);
    bus.data_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    drive(8'd1, 8'd99, 8'd1, 2'b10, 1'b1);
    step();
    bus.data_valid = 1'b0;
    chk("post-rst not early", int'(bus.data_out_valid), 0);
    step();
    chk("post-rst valid", int'(bus.data_out_valid), 1);
    chk("post-rst gray", int'(bus.gray_out), 99);
    step();

    // Off-curve pixels and the miss counter
    send_one(8'd10, 8'd20, 8'd30, 2'b01);
    chk("off miss_out", int'(bus.miss_out), 1);
    chk("off gray", int'(bus.gray_out), 18);
    chk("off cnt before accept", int'(miss_cnt), 0);
    step();
    chk("off cnt after accept", int'(miss_cnt), 1);
    drive(8'd10, 8'd20, 8'd30, 2'b01, 1'b1);
    miss_clr = 1'b1;
    step();
    miss_clr = 1'b0;
    bus.data_valid = 1'b0;
    chk("clr on accept", int'(miss_cnt), 0);
    step();
    chk("2nd off miss_out", int'(bus.miss_out), 1);
    miss_clr = 1'b1;
    step();
    miss_clr = 1'b0;
    chk("clr beats inc", int'(miss_cnt), 0);
    for (int k = 1; k <= 4; k++) begin
      send_one(8'd10, 8'd20, 8'd30, 2'b01);
      step();
      chk($sformatf("sat cnt%0d", k), int'(miss_cnt), (k > 3) ? 3 : k);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/colormap_to_gray.md
# colormap_to_gray

Pixel-stream converter from 24-bit RGB back to 8-bit gray. Sits downstream of the pseudo-colour stage: it either inverts the 4-segment jet colormap to recover the original gray index, or computes a generic gray value from arbitrary RGB. The core is a 2-stage valid/ready pipeline with backpressure. A saturating counter tracks pixels that fall off the jet curve.

## Interface
Parameters:
- `CNT_W`, default 16: width of the off-curve pixel counter.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `r_in`, `g_in`, `b_in`, input, 8 each: input pixel.
- `mode_sel`, input, 2: conversion mode, sampled with each accepted pixel.
- `data_valid`, input, 1: input pixel valid.
- `in_ready`, output, 1: block can accept a pixel this cycle.
- `gray_out`, output, 8: converted gray value.
- `miss_out`, output, 1: pixel was not on the jet curve (mode 01 only).
- `data_out_valid`, output, 1: output valid.
- `out_ready`, input, 1: downstream accepts the output.
- `miss_clr`, input, 1: synchronous clear of `miss_cnt`.
- `miss_cnt`, output, `CNT_W`: saturating count of `miss_out` pixels that were accepted downstream.

## Operation
Modes:
- **00, luminance:** `(77R + 150G + 29B + 128) >> 8`. Use a 16-bit sum; the maximum is 65408, so the result never overflows 255.
- **01, inverse jet:** rules are evaluated in this priority order.
  1. R==0, B==255, G!=255 → 64 + (G>>2).
  2. R==0, G==0 → B>>2.
  3. G==255, R!=255 → 128 + (R>>2).
  4. R==255, B==0 → 192 + ((255−G)>>2).
  - If no rule matches, output the mode-00 value and set `miss_out`=1.
  - Every gray 0..255 encoded by the jet colormap (0–63 blue ramp, 64–127 green ramp, 128–191 red up/blue down, 192–255 green down) must decode exactly.
- **10, channel:** output G unchanged.
- **11, value:** max(R, G, B).
- `miss_out`=0 in every mode except 01.

Pipeline:
- Stage 1 registers the inputs, the mode, the three luma products and the rule-match flags.
- Stage 2 selects the result and registers `gray_out`, `miss_out` and `data_out_valid`.

Handshake and backpressure:
- `adv = !data_out_valid || out_ready`, and `in_ready = adv`.
- A pixel is accepted when `data_valid && in_ready`.
- When `adv`=0, both stages hold their contents, including the stage-1 valid bit.
- When `adv`=1 and no pixel is accepted, a bubble (valid=0) enters stage 1.
- Outputs hold stable while `data_out_valid && !out_ready`.

Miss counter:
- Increments by 1 when `data_out_valid && out_ready && miss_out`.
- Saturates at 2^CNT_W−1.
- If `miss_clr` and an increment occur in the same cycle, the counter is set to 0 (clear wins).

## Timing
- **Reset values:** `gray_out`=0, `miss_out`=0, `data_out_valid`=0, `miss_cnt`=0, all internal valid bits 0, `in_ready`=1.
- **Latency:** a pixel accepted at edge N is presented at edge N+2 when there is no stall.
- **Throughput:** 1 pixel per clock while `out_ready`=1.
- **Stalls:** each cycle with `data_out_valid && !out_ready` adds one cycle of latency to every pixel in flight. No pixel is dropped or duplicated.
- **Reset mid-stream:** asserting `rst_n`=0 flushes both stages immediately, and pixels in flight are discarded. The first pixel after release appears 2 cycles after it is accepted.
- **Mode changes:** `mode_sel` may change every cycle. Each pixel uses the mode sampled with it.

## Configuration
- `C2G_ROUND_EN` defined: the luminance path adds +128 before `>>8` (round to nearest).
- Undefined: no rounding constant; the luminance path truncates.
- This affects mode 00 and the mode-01 miss fallback only. Pipeline timing is identical in both builds.

## Test plan
- **Reset:** assert `rst_n`=0 mid-stream → all outputs read 0 and `in_ready`=1. After release, output resumes with 2-cycle latency.
- **Luminance, back-to-back:** mode 00, (255,0,0) then (255,255,255) on consecutive cycles → 77 then 255 (76 then 255 with `C2G_ROUND_EN` undefined), valid on consecutive cycles.
- **Inverse-jet round trip:** mode 01, sweep all 256 jet-encoded pixels (e.g. gray 64→(0,0,255), 128→(0,255,255), 191→(252,255,3), 255→(255,3,0)) → each recovers its original index with `miss_out`=0.
- **Off-curve pixels:** mode 01, (10,20,30) → `miss_out`=1, `gray_out`=luminance value, `miss_cnt` 0→1. Pulse `miss_clr` in the same cycle as a second off-curve pixel is accepted → `miss_cnt`=0.
- **Backpressure:** stream 5 pixels, hold `out_ready`=0 for 3 cycles → `in_ready`=0, outputs stable. After release, all 5 pixels appear in order with no loss or duplication.
- **Modes 10 and 11:** (12,200,45) → 200 in both mode 10 and mode 11. (250,3,7) in mode 11 → 250.
